// File: rtl/vga_sync_receiver.sv
// Receive side of the Breakout VGA path. Recovers pixel coordinates from the
// sync stream, qualifies lock to the line/frame timing and checksums each visible frame.
module vga_sync_receiver #(
  parameter int H_VISIBLE    = 640,
  parameter int H_SYNC_START = 656,
  parameter int H_SYNC_LEN   = 96,
  parameter int H_TOTAL      = 800,
  parameter int V_VISIBLE    = 480,
  parameter int V_SYNC_START = 490,
  parameter int V_TOTAL      = 525,
  parameter int LOCK_LINES   = 4
) (
  input  logic        CLK_25MH,
  input  logic        reset_n,
  input  logic [5:0]  RGB,
  input  logic        hsync,
  input  logic        vsync,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [5:0]  pix_rgb,
  output logic        pix_valid,
  output logic        locked,
  output logic        sync_err,
  output logic [15:0] frame_sum,
  output logic        frame_done
);

  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] H_SS   = 10'(H_SYNC_START);
  localparam logic [9:0] H_LEN  = 10'(H_SYNC_LEN);
  localparam logic [9:0] H_TOT  = 10'(H_TOTAL);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] V_SS   = 10'(V_SYNC_START);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [2:0] LOCK_N = 3'(LOCK_LINES);
  localparam logic [9:0] SAT    = 10'd1023;

  typedef enum logic [1:0] {UNLOCKED, H_LOCK, LOCKED} state_t;

  state_t      state, state_next;
  logic        hs_q, vs_q;
  logic [9:0]  x_cnt, y_cnt, per_cnt, low_cnt, low_w;
  logic [2:0]  good_cnt;
  logic        meas_on;
  logic [15:0] acc;
  logic        frame_armed;

  logic        hs_fall, hs_rise, vs_fall;
  logic [9:0]  x_cur, y_cur;
  logic        x_wrap, visible;
  logic        line_good, line_bad, vs_bad, hs_stuck, lock_err;

  assign hs_fall   = hs_q & ~hsync;
  assign hs_rise   = ~hs_q & hsync;
  assign vs_fall   = vs_q & ~vsync;
  assign x_cur     = hs_fall ? H_SS : x_cnt;
  assign y_cur     = vs_fall ? V_SS : y_cnt;
  assign x_wrap    = (x_cur == H_LAST);
  assign visible   = (x_cur < H_VIS) && (y_cur < V_VIS);
  // The first hs_fall after reset has no preceding period, so meas_on gates it out.
  assign line_good = meas_on && (per_cnt == H_LAST) && (low_w == H_LEN);
  assign line_bad  = hs_fall && !line_good;
  assign vs_bad    = vs_fall && ((x_cur != 10'd0) || (y_cnt != V_SS));
  assign hs_stuck  = (per_cnt == H_TOT) && !hs_fall;
  assign locked    = (state == LOCKED);

  always_comb begin
    state_next = state;
    lock_err   = 1'b0;
    case (state)
      UNLOCKED: if (good_cnt == LOCK_N && !line_bad) state_next = H_LOCK;
      H_LOCK: begin
        if (line_bad)                          state_next = UNLOCKED;
        else if (vs_fall && x_cur == 10'd0)    state_next = LOCKED;
      end
      LOCKED: begin
        if (line_bad || vs_bad || hs_stuck) begin
          state_next = UNLOCKED;
          lock_err   = 1'b1;
        end
      end
      default: state_next = UNLOCKED;
    endcase
  end

  always_ff @(posedge CLK_25MH or negedge reset_n) begin
    if (!reset_n) begin
      state    <= UNLOCKED;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      x_cnt    <= '0;
      y_cnt    <= '0;
      per_cnt  <= '0;
      low_cnt  <= '0;
      low_w    <= '0;
      good_cnt <= '0;
      meas_on  <= 1'b0;
    end else begin
      state <= state_next;
      hs_q  <= hsync;
      vs_q  <= vsync;
      x_cnt <= x_wrap ? 10'd0 : x_cur + 10'd1;
      if (x_wrap) y_cnt <= (y_cur == V_LAST) ? 10'd0 : y_cur + 10'd1;
      else        y_cnt <= y_cur;

      if (hs_fall)             per_cnt <= '0;
      else if (per_cnt != SAT) per_cnt <= per_cnt + 10'd1;
      if (hs_fall) meas_on <= 1'b1;

      if (!hsync) begin
        if (hs_fall)             low_cnt <= 10'd1;
        else if (low_cnt != SAT) low_cnt <= low_cnt + 10'd1;
      end else begin
        low_cnt <= '0;
        if (hs_rise) low_w <= low_cnt;
      end

      if (hs_fall) begin
        if (!line_good)              good_cnt <= '0;
        else if (good_cnt != LOCK_N) good_cnt <= good_cnt + 3'd1;
      end
    end
  end

  // A frame is only reported when lock held across both of its bounding vs_falls.
  always_ff @(posedge CLK_25MH or negedge reset_n) begin
    if (!reset_n) begin
      acc         <= '0;
      frame_armed <= 1'b0;
      frame_sum   <= '0;
      frame_done  <= 1'b0;
      sync_err    <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
      pix_valid   <= 1'b0;
    end else begin
      if (vs_fall)      acc <= '0;
      else if (visible) acc <= acc + {10'd0, RGB};

      if (state == UNLOCKED) frame_armed <= 1'b0;
      else if (vs_fall)      frame_armed <= (state_next == LOCKED);

      frame_done <= 1'b0;
      if (vs_fall && frame_armed && state == LOCKED && state_next == LOCKED) begin
        frame_sum  <= acc;
        frame_done <= 1'b1;
      end

      sync_err  <= lock_err;
      pix_x     <= x_cur;
      pix_y     <= y_cur;
      pix_rgb   <= RGB;
      pix_valid <= locked & visible;
    end
  end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver: drives a scaled-down raster frame by frame
// and compares coordinates, lock behaviour and checksums against hand-computed values.
module tb_vga_sync_receiver;

  // Scaled timing keeps each frame to 2736 clocks.
  localparam int HV = 48, HSS = 52, HSL = 10, HT = 72;
  localparam int VV = 30, VSS = 33, VT = 38, LL = 4;

  logic        CLK_25MH = 1'b0;
  logic        reset_n;
  logic [5:0]  RGB;
  logic        hsync, vsync;
  logic [9:0]  pix_x, pix_y;
  logic [5:0]  pix_rgb;
  logic        pix_valid, locked, sync_err, frame_done;
  logic [15:0] frame_sum;

  int checks = 0, errors = 0;
  int sync_err_count = 0, frame_done_count = 0;

  always #20 CLK_25MH = ~CLK_25MH;

  vga_sync_receiver #(
    .H_VISIBLE(HV), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL), .H_TOTAL(HT),
    .V_VISIBLE(VV), .V_SYNC_START(VSS), .V_TOTAL(VT), .LOCK_LINES(LL)
  ) dut (
    .CLK_25MH(CLK_25MH), .reset_n(reset_n), .RGB(RGB), .hsync(hsync), .vsync(vsync),
    .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb), .pix_valid(pix_valid),
    .locked(locked), .sync_err(sync_err), .frame_sum(frame_sum), .frame_done(frame_done)
  );

  always @(negedge CLK_25MH) begin
    if (sync_err === 1'b1)   sync_err_count++;
    if (frame_done === 1'b1) frame_done_count++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drives one sample at a negedge and returns on the next negedge, when the
  // registered outputs describe that sample.
  task automatic applyStimulus(input logic [5:0] rgb_v, input logic hs_v, input logic vs_v);
    RGB   = rgb_v;
    hsync = hs_v;
    vsync = vs_v;
    @(negedge CLK_25MH);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_pix_x"}, pix_x, 0);
    checkOutput({tag, "_pix_y"}, pix_y, 0);
    checkOutput({tag, "_pix_rgb"}, pix_rgb, 0);
    checkOutput({tag, "_pix_valid"}, pix_valid, 0);
    checkOutput({tag, "_locked"}, locked, 0);
    checkOutput({tag, "_sync_err"}, sync_err, 0);
    checkOutput({tag, "_frame_sum"}, frame_sum, 0);
    checkOutput({tag, "_frame_done"}, frame_done, 0);
  endtask

  // mode: 0 black, 1 8x8 ball of 56 at (10,20), 2 white visible area.
  // short_line: line whose hsync pulse is one clock short; vs_x: x where vsync falls;
  // rst_line: line on which reset pulses at x=40. Negative disables.
  task automatic runFrame(input int mode, input int short_line, input int vs_x,
                          input int rst_line, input logic exp_done,
                          input logic [15:0] exp_sum, input logic exp_lock);
    int pos, hlen;
    logic [5:0] rgb;
    logic hs, vs;
    for (int y = 0; y < VT; y++) begin
      for (int x = 0; x < HT; x++) begin
        pos  = y * HT + x;
        hlen = (y == short_line) ? HSL - 1 : HSL;
        rgb  = 6'd0;
        if (mode == 1 && x >= 10 && x < 18 && y >= 20 && y < 28) rgb = 6'd56;
        if (mode == 2 && x < HV && y < VV) rgb = 6'd63;
        hs = !(x >= HSS && x < HSS + hlen);
        vs = !(pos >= VSS * HT + vs_x && pos < (VSS + 2) * HT + vs_x);
        if (y == rst_line && x == 40) begin
          reset_n = 1'b0;
          #1;
          checkAllZero("midreset");
        end
        applyStimulus(rgb, hs, vs);
        if (y == rst_line && x == 40) reset_n = 1'b1;

        if (mode == 1) begin
          if (x == 0 && y == 0) begin
            checkOutput("ywrap_pix_y", pix_y, 0);
            checkOutput("ywrap_pix_x", pix_x, 0);
            checkOutput("ywrap_pix_valid", pix_valid, 1);
          end
          if (x == 9 && y == 20)  checkOutput("pre_ball_rgb", pix_rgb, 0);
          if (x == 10 && y == 20) begin
            checkOutput("ball_pix_x", pix_x, 10);
            checkOutput("ball_pix_y", pix_y, 20);
            checkOutput("ball_pix_rgb", pix_rgb, 56);
            checkOutput("ball_pix_valid", pix_valid, 1);
          end
          if (x == HV && y == 20) begin
            checkOutput("hblank_pix_x", pix_x, HV);
            checkOutput("hblank_pix_valid", pix_valid, 0);
          end
          if (x == HT - 1 && y == 21) checkOutput("line_end_pix_x", pix_x, HT - 1);
          if (x == 0 && y == 22) begin
            checkOutput("xwrap_pix_x", pix_x, 0);
            checkOutput("xwrap_pix_y", pix_y, 22);
          end
        end
        if (short_line >= 0 && y == short_line + 1 && x == HSS) begin
          checkOutput("short_hs_sync_err", sync_err, 1);
          checkOutput("short_hs_locked", locked, 0);
        end
        if (rst_line >= 0 && y == VSS - 1 && x == 0)
          checkOutput("post_reset_unlocked", locked, 0);
        if (y == VSS && x == vs_x) begin
          checkOutput("vs_frame_done", frame_done, exp_done);
          if (exp_done) checkOutput("vs_frame_sum", frame_sum, exp_sum);
          checkOutput("vs_locked", locked, exp_lock);
          if (vs_x != 0) checkOutput("vs_misplaced_sync_err", sync_err, 1);
        end
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    RGB     = 6'd0;
    hsync   = 1'b1;
    vsync   = 1'b1;
    repeat (3) @(negedge CLK_25MH);
    checkAllZero("reset");
    reset_n = 1'b1;

    runFrame(0, -1, 0, -1, 1'b0, 16'h0000, 1'b1);
    runFrame(0, -1, 0, -1, 1'b1, 16'h0000, 1'b1);
    runFrame(1, -1, 0, -1, 1'b1, 16'd3584, 1'b1);
    runFrame(2, -1, 0, -1, 1'b1, 16'h6260, 1'b1);
    checkOutput("no_sync_err_nominal", sync_err_count, 0);
    runFrame(0, 10, 0, -1, 1'b0, 16'h0000, 1'b1);
    runFrame(2, -1, 0, -1, 1'b1, 16'h6260, 1'b1);
    runFrame(0, -1, 5, -1, 1'b0, 16'h0000, 1'b0);
    runFrame(0, -1, 0, -1, 1'b0, 16'h0000, 1'b1);
    runFrame(0, -1, 0, 20, 1'b0, 16'h0000, 1'b1);
    runFrame(0, -1, 0, -1, 1'b1, 16'h0000, 1'b1);

    checkOutput("sync_err_total", sync_err_count, 2);
    checkOutput("frame_done_total", frame_done_count, 5);
    checkOutput("final_frame_sum", frame_sum, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
